// File: rtl/rqb_pkg.sv
// Shared constants and payload type for the request queue bank.
package rqb_pkg;
  localparam int N_AGENTS = 3;
  localparam int DATA_W   = 64;
  localparam int DEPTH    = 4;

  typedef logic [DATA_W-1:0] order_t;
endpackage

// File: rtl/req_queue_bank_if.sv
// Handshake bundle between the agents, the queue bank and the round-robin arbiter.
interface req_queue_bank_if #(
  parameter int N      = rqb_pkg::N_AGENTS,
  parameter int DATA_W = rqb_pkg::DATA_W,
  localparam int SW    = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]        in_valid;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]        in_ready;
  logic [N-1:0]        req;
  logic [N-1:0]        grant;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [SW-1:0]       out_src;
  logic [15:0]         stale_cnt;
  logic                grant_err;

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_valid, out_data, out_src, stale_cnt, grant_err
  );

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_valid, out_data, out_src, stale_cnt, grant_err
  );
endinterface

// File: rtl/rqb_fifo.sv
// Single-agent FIFO: DEPTH entries, power-of-two pointers that wrap naturally.
module rqb_fifo
  import rqb_pkg::*;
#(
  parameter int DATA_W = rqb_pkg::DATA_W,
  parameter int DEPTH  = rqb_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  // Local guards keep the occupancy consistent even if the caller misbehaves.
  always_comb begin
    do_push = push && (count != DEPTH_C);
    do_pop  = pop && (count != {CW{1'b0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/req_queue_bank.sv
// Per-agent order queues feeding a round-robin arbiter; stale/illegal grant
// statistics are built only when REQ_QUEUE_BANK_STATS_EN is defined.
module req_queue_bank
  import rqb_pkg::*;
#(
  parameter int N      = rqb_pkg::N_AGENTS,
  parameter int DATA_W = rqb_pkg::DATA_W,
  parameter int DEPTH  = rqb_pkg::DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
  input logic              clk,
  input logic              rst,
  req_queue_bank_if.slave  bus
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]     count [N];
  logic [DATA_W-1:0] head  [N];
  logic [N-1:0]      push;
  logic [N-1:0]      pop;
  logic [N-1:0]      nonempty;
  logic [N-1:0]      ready;
  logic [N-1:0]      req_vec;
  logic              grant_multi;
  logic              grant_onehot;
  logic [SW-1:0]     sel_src;
  logic [DATA_W-1:0] sel_data;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SW-1:0]     out_src_q;
  logic [15:0]       stale_cnt_q;
  logic              grant_err_q;

  always_comb begin
    grant_multi  = (bus.grant & (bus.grant - N'(1))) != {N{1'b0}};
    grant_onehot = (bus.grant != {N{1'b0}}) && !grant_multi;
  end

  // A granted entry is no longer requested, so a registered grant cannot double-pop.
  always_comb begin
    ready    = {N{1'b0}};
    req_vec  = {N{1'b0}};
    push     = {N{1'b0}};
    pop      = {N{1'b0}};
    nonempty = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      nonempty[i] = count[i] != {CW{1'b0}};
      ready[i]    = !rst && (count[i] < DEPTH_C);
      req_vec[i]  = count[i] > (bus.grant[i] ? CW'(1) : CW'(0));
      push[i]     = bus.in_valid[i] && ready[i];
      pop[i]      = grant_onehot && bus.grant[i] && nonempty[i];
    end
  end

  assign bus.in_ready = ready;
  assign bus.req      = req_vec;

  for (genvar g = 0; g < N; g++) begin : g_agent
    rqb_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (bus.in_data[g*DATA_W +: DATA_W]),
      .head      (head[g]),
      .count     (count[g])
    );
  end

  // pop is at most one-hot, so an AND-OR mux selects the popped head.
  always_comb begin
    sel_src  = {SW{1'b0}};
    sel_data = {DATA_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_src  = sel_src  | (SW'(i) & {SW{pop[i]}});
      sel_data = sel_data | (head[i] & {DATA_W{pop[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_src_q   <= {SW{1'b0}};
    end else begin
      out_valid_q <= |pop;
      if (|pop) begin
        out_data_q <= sel_data;
        out_src_q  <= sel_src;
      end
    end
  end

`ifdef REQ_QUEUE_BANK_STATS_EN
  logic stale;

  always_comb begin
    stale = grant_onehot && ((bus.grant & ~nonempty) != {N{1'b0}});
  end

  // Stale counter saturates; illegal-grant flag holds until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_cnt_q <= 16'h0000;
      grant_err_q <= 1'b0;
    end else begin
      if (stale && (stale_cnt_q != 16'hFFFF)) stale_cnt_q <= stale_cnt_q + 16'h0001;
      if (grant_multi) grant_err_q <= 1'b1;
    end
  end
`else
  assign stale_cnt_q = 16'h0000;
  assign grant_err_q = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.stale_cnt = stale_cnt_q;
  assign bus.grant_err = grant_err_q;
endmodule

// File: tb/tb_req_queue_bank.sv
// Directed and randomized bench for req_queue_bank against a queue-based reference
// model and a round-robin arbiter model (honours REQ_QUEUE_BANK_STATS_EN).
module tb_req_queue_bank;
  import rqb_pkg::*;

  localparam int NA = 3;
  localparam int DW = 64;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_queue_bank_if #(.N(NA), .DATA_W(DW)) bus ();

  req_queue_bank #(.N(NA), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  order_t     mq [NA][$];
  order_t     din [NA];
  logic       exp_ov = 1'b0;
  order_t     exp_od = 64'h0;
  logic [1:0] exp_os = 2'd0;
  int         exp_stale = 0;
  logic       exp_err = 1'b0;
  logic [2:0] last_req = 3'b000;
  logic [2:0] last_acc = 3'b000;
  int         rr_last = NA - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stale_exp();
`ifdef REQ_QUEUE_BANK_STATS_EN
    return (exp_stale > 65535) ? 16'hFFFF : 16'(exp_stale);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic err_exp();
`ifdef REQ_QUEUE_BANK_STATS_EN
    return exp_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic rnd_data();
    for (int i = 0; i < NA; i++) din[i] = {$urandom(), $urandom()};
  endtask

  task automatic rr_pick(input logic [2:0] rq, output logic [2:0] g);
    bit found = 1'b0;
    g = 3'b000;
    for (int k = 1; k <= NA; k++) begin
      int idx = (rr_last + k) % NA;
      if (!found && rq[idx]) begin
        g[idx]  = 1'b1;
        rr_last = idx;
        found   = 1'b1;
      end
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic [2:0] v, input logic [2:0] g);
    logic [2:0] rdy;
    logic [2:0] rq;
    int ones;
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("out_data", bus.out_data, exp_od);
      chk("out_src", 64'(bus.out_src), 64'(exp_os));
    end
    chk("stale_cnt", 64'(bus.stale_cnt), 64'(stale_exp()));
    chk("grant_err", 64'(bus.grant_err), 64'(err_exp()));
    bus.in_valid = v;
    bus.in_data  = {din[2], din[1], din[0]};
    bus.grant    = g;
    #1;
    for (int i = 0; i < NA; i++) begin
      rdy[i] = mq[i].size() < DP;
      rq[i]  = mq[i].size() > (g[i] ? 1 : 0);
    end
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("req", 64'(bus.req), 64'(rq));
    last_req = rq;
    ones = $countones(g);
    exp_ov = 1'b0;
    for (int i = 0; i < NA; i++) last_acc[i] = v[i] && rdy[i];
    for (int i = 0; i < NA; i++) begin
      if (ones == 1 && g[i]) begin
        if (mq[i].size() > 0) begin
          exp_ov = 1'b1;
          exp_od = mq[i].pop_front();
          exp_os = 2'(i);
        end else begin
          exp_stale++;
        end
      end
    end
    if (ones > 1) exp_err = 1'b1;
    for (int i = 0; i < NA; i++) if (last_acc[i]) mq[i].push_back(din[i]);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.in_valid = 3'b000;
    bus.grant    = 3'b000;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_req", 64'(bus.req), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_data", bus.out_data, 64'h0);
    chk("rst_out_src", 64'(bus.out_src), 64'h0);
    chk("rst_stale_cnt", 64'(bus.stale_cnt), 64'h0);
    chk("rst_grant_err", 64'(bus.grant_err), 64'h0);
    bus.in_valid = 3'b111;
    @(negedge clk);
    chk("rst_hold_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_hold_req", 64'(bus.req), 64'h0);
    chk("rst_hold_out_valid", 64'(bus.out_valid), 64'h0);
    bus.in_valid = 3'b000;
    rst = 1'b0;
    for (int i = 0; i < NA; i++) mq[i].delete();
    exp_ov = 1'b0;
    exp_stale = 0;
    exp_err = 1'b0;
    rr_last = NA - 1;
  endtask

  initial begin
    int remaining [NA];
    int delivered;
    int prev_src;
    logic [2:0] next_g;
    logic [2:0] v;
    logic [2:0] g;

    bus.in_valid = 3'b000;
    bus.in_data  = '0;
    bus.grant    = 3'b000;
    for (int i = 0; i < NA; i++) din[i] = 64'h0;
    @(negedge clk);
    apply_reset();

    // Single order round trip through the arbiter loop.
    rnd_data();
    din[0] = 64'hA0;
    step(3'b001, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b001);
    step(3'b000, 3'b000);
    chk("t036_last_data", bus.out_data, 64'hA0);
    step(3'b000, 3'b000);

    // Fill agent 1, refuse a fifth push, pop once, then drain.
    for (int k = 0; k < 4; k++) begin rnd_data(); step(3'b010, 3'b000); end
    rnd_data();
    step(3'b010, 3'b000);
    step(3'b000, 3'b010);
    step(3'b000, 3'b000);
    for (int k = 0; k < 3; k++) step(3'b000, 3'b010);
    step(3'b000, 3'b000);

    // Stale grant on an empty queue.
    step(3'b000, 3'b010);
    step(3'b000, 3'b000);

    // Full agent 2: push refused while popping; then push and pop together at count 3.
    for (int k = 0; k < 4; k++) begin rnd_data(); step(3'b100, 3'b000); end
    rnd_data();
    step(3'b100, 3'b100);
    rnd_data();
    step(3'b100, 3'b100);
    for (int k = 0; k < 3; k++) step(3'b000, 3'b100);
    step(3'b000, 3'b000);

    // Illegal grant, then reset with orders in flight.
    rnd_data();
    step(3'b111, 3'b011);
    step(3'b000, 3'b000);
    rnd_data();
    step(3'b001, 3'b000);
    apply_reset();
    rnd_data();
    step(3'b001, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b001);
    step(3'b000, 3'b000);

    // Six orders per agent against the round-robin arbiter model.
    for (int i = 0; i < NA; i++) remaining[i] = 6;
    delivered = 0;
    prev_src  = NA - 1;
    next_g    = 3'b000;
    for (int cyc = 0; cyc < 300 && delivered < 18; cyc++) begin
      rnd_data();
      for (int i = 0; i < NA; i++) v[i] = remaining[i] > 0;
      step(v, next_g);
      for (int i = 0; i < NA; i++) if (last_acc[i]) remaining[i]--;
      if (exp_ov) begin
        delivered++;
        chk("rr_rotate", 64'(bus.out_src), 64'((prev_src + 1) % NA));
        prev_src = int'(exp_os);
      end
      rr_pick(last_req, next_g);
    end
    chk("rr_delivered", 64'(delivered), 64'd18);
    step(3'b000, next_g);
    step(3'b000, 3'b000);

    // Random pushes with a mix of arbiter, random and idle grants.
    next_g = 3'b000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rnd_data();
      v = 3'($urandom());
      case ($urandom_range(3, 0))
        0, 1:    g = next_g;
        2:       g = 3'($urandom());
        default: g = 3'b000;
      endcase
      step(v, g);
      rr_pick(last_req, next_g);
    end
    step(3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
